// File: rtl/common_pkg.sv
// -----------------------------------------------------------------------------
// common_pkg
// Shared types and constants for the pipeline run controller.
//   run_state_t         : run-control FSM states (IDLE, RUN, HALT, STEP)
//   stage_ctrl_t        : five pipeline register enables plus three flushes
//   STALL_LIMIT_DEFAULT : default consecutive-stall watchdog threshold
//   CTRL_*              : canned stage-control patterns used by the sequencer
// -----------------------------------------------------------------------------
package common_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        STEP = 2'd3
    } run_state_t;

    // Field order (MSB first) is fixed so the canned patterns below read
    // left to right as fetch, decode, execute, mem, wb | dflush, eflush, mflush.
    typedef struct packed {
        logic fetch_en;
        logic decode_en;
        logic execute_en;
        logic mem_en;
        logic wb_en;
        logic decode_flush;
        logic execute_flush;
        logic mem_flush;
    } stage_ctrl_t;

    localparam int STALL_LIMIT_DEFAULT = 64;

    // Everything frozen, nothing flushed (HALT, reset).
    localparam stage_ctrl_t CTRL_HOLD       = 8'b0000_0000;
    // Frozen but all younger stages flushed (IDLE, program reload).
    localparam stage_ctrl_t CTRL_FLUSH_ONLY = 8'b0000_0111;
    // Normal flow: everything advances.
    localparam stage_ctrl_t CTRL_FLOW       = 8'b1111_1000;
    // Taken branch in MEM: advance and squash the three younger slots.
    localparam stage_ctrl_t CTRL_BRANCH     = 8'b1111_1111;
    // Multicycle execute busy: front end holds, bubble goes into MEM.
    localparam stage_ctrl_t CTRL_BUBBLE     = 8'b0001_1001;
    // Load-use hazard: IF/ID hold, bubble goes into EX.
    localparam stage_ctrl_t CTRL_HAZARD     = 8'b0011_1010;
    // ebreak retiring: let WB complete, squash everything younger, keep the PC.
    localparam stage_ctrl_t CTRL_SQUASH     = 8'b0111_1111;

endpackage

// File: rtl/pipe_perf_counters.sv
// -----------------------------------------------------------------------------
// pipe_perf_counters
// Free-running cycle and retired-instruction counters for the debug view.
// Both wrap at 2^CNT_W, clear synchronously on 'clear' and otherwise hold.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   clear          : synchronous clear (program start), wins over counting
//   active         : count this cycle into cycle_count
//   retire         : count this cycle into instret_count
//   cycle_count    : active cycles since last clear
//   instret_count  : retired instructions since last clear
// -----------------------------------------------------------------------------
module pipe_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             active,
    input  logic             retire,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cycle_r;
    logic [CNT_W-1:0] instret_r;

    // Active-cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_r <= CNT_ZERO;
        end else if (clear) begin
            cycle_r <= CNT_ZERO;
        end else if (active) begin
            cycle_r <= cycle_r + CNT_ONE;
        end else begin
            cycle_r <= cycle_r;
        end
    end

    // Retired-instruction counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_r <= CNT_ZERO;
        end else if (clear) begin
            instret_r <= CNT_ZERO;
        end else if (retire) begin
            instret_r <= instret_r + CNT_ONE;
        end else begin
            instret_r <= instret_r;
        end
    end

    assign cycle_count   = cycle_r;
    assign instret_count = instret_r;

endmodule

// File: rtl/pipeline_run_controller.sv
// -----------------------------------------------------------------------------
// pipeline_run_controller
// Central sequencer for the 5-stage RISC-V pipeline. Owns run control
// (IDLE / RUN / HALT / STEP) and converts hazard, bubble and branch events
// into per-stage register enables and flushes with zero-cycle latency
// (outputs are combinational from the registered state and current inputs).
//
// Optional build macro: PIPE_CTRL_WATCHDOG_EN
//   defined   : a consecutive-stall counter trips after STALL_LIMIT stalled
//               RUN cycles, sets sticky stall_timeout and forces RUN -> HALT.
//   undefined : stall_timeout is tied low and no stall counter exists.
//
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   start           : 1 = program loaded; 0 forces IDLE (highest priority)
//   halt_req        : ebreak in WB, qualified by wb_valid
//   step_req        : pulse, advance one cycle while halted
//   resume_req      : pulse, HALT -> RUN (wins over step_req)
//   hazard_detected : load-use hazard from decode
//   insert_bubble   : multicycle execute unit busy
//   branch_taken    : branch/jump resolved taken in MEM
//   wb_valid        : real instruction present in WB
//   *_en            : pipeline register / PC enables
//   *_flush         : bubble injection into ID / EX / MEM
//   running, halted : state == RUN, state == HALT
//   stall_timeout   : sticky watchdog flag
//   cycle_count     : RUN/STEP cycles since last program start
//   instret_count   : retired instructions since last program start
// -----------------------------------------------------------------------------
module pipeline_run_controller
    import common_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int STALL_LIMIT = STALL_LIMIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             resume_req,
    input  logic             hazard_detected,
    input  logic             insert_bubble,
    input  logic             branch_taken,
    input  logic             wb_valid,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             decode_flush,
    output logic             execute_flush,
    output logic             mem_flush,
    output logic             running,
    output logic             halted,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    run_state_t  state_r;
    run_state_t  state_s;
    stage_ctrl_t rules_s;
    stage_ctrl_t ctrl_s;
    stage_ctrl_t out_s;
    logic        counter_clear_s;
    logic        stall_cycle_s;
    logic        watchdog_trip_s;
    logic        active_s;
    logic        retire_s;

    // Run-control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Stage rules for a flowing pipeline; a taken branch cancels any
    // multicycle op or hazard because those instructions are being squashed.
    always_comb begin
        rules_s = CTRL_FLOW;
        if (branch_taken) begin
            rules_s = CTRL_BRANCH;
        end else if (insert_bubble) begin
            rules_s = CTRL_BUBBLE;
        end else if (hazard_detected) begin
            rules_s = CTRL_HAZARD;
        end else begin
            rules_s = CTRL_FLOW;
        end
    end

    // Next-state and stage-control selection.
    always_comb begin
        state_s         = state_r;
        ctrl_s          = CTRL_HOLD;
        counter_clear_s = 1'b0;
        if (!start) begin
            state_s = IDLE;
            ctrl_s  = CTRL_FLUSH_ONLY;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s         = RUN;
                    ctrl_s          = CTRL_FLUSH_ONLY;
                    counter_clear_s = 1'b1;
                end
                RUN, STEP: begin
                    if (halt_req && wb_valid) begin
                        state_s = HALT;
                        ctrl_s  = CTRL_SQUASH;
                    end else if (watchdog_trip_s) begin
                        // Watchdog stops the machine as-is; nothing squashed.
                        state_s = HALT;
                        ctrl_s  = rules_s;
                    end else if (state_r == STEP) begin
                        state_s = HALT;
                        ctrl_s  = rules_s;
                    end else begin
                        state_s = RUN;
                        ctrl_s  = rules_s;
                    end
                end
                HALT: begin
                    ctrl_s = CTRL_HOLD;
                    if (resume_req) begin
                        state_s = RUN;
                    end else if (step_req) begin
                        state_s = STEP;
                    end else begin
                        state_s = HALT;
                    end
                end
                default: begin
                    state_s = IDLE;
                    ctrl_s  = CTRL_FLUSH_ONLY;
                end
            endcase
        end
    end

    // Outputs are forced quiet while reset is held, independent of inputs.
    assign out_s = rst ? ctrl_s : CTRL_HOLD;

    assign fetch_en      = out_s.fetch_en;
    assign decode_en     = out_s.decode_en;
    assign execute_en    = out_s.execute_en;
    assign mem_en        = out_s.mem_en;
    assign wb_en         = out_s.wb_en;
    assign decode_flush  = out_s.decode_flush;
    assign execute_flush = out_s.execute_flush;
    assign mem_flush     = out_s.mem_flush;
    assign running       = (state_r == RUN);
    assign halted        = (state_r == HALT);

    // Only RUN counts toward the watchdog; a single STEP never trips it.
    assign stall_cycle_s = start && (state_r == RUN) && !rules_s.fetch_en;

`ifdef PIPE_CTRL_WATCHDOG_EN
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    logic [STALL_W-1:0] stall_cnt_r;
    logic               timeout_r;

    // Trip on the STALL_LIMIT-th consecutive stalled cycle.
    assign watchdog_trip_s = stall_cycle_s &&
                             (stall_cnt_r == STALL_W'(STALL_LIMIT - 1));

    // Consecutive-stall counter, cleared by any non-stalled cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= {STALL_W{1'b0}};
        end else if (stall_cycle_s) begin
            stall_cnt_r <= stall_cnt_r + STALL_W'(1);
        end else begin
            stall_cnt_r <= {STALL_W{1'b0}};
        end
    end

    // Sticky timeout flag, released only by a fresh program start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_r <= 1'b0;
        end else if (counter_clear_s) begin
            timeout_r <= 1'b0;
        end else if (watchdog_trip_s) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign stall_timeout = timeout_r;
`else
    logic [31:0] unused_stall_limit_s;

    assign unused_stall_limit_s = 32'(STALL_LIMIT);
    assign watchdog_trip_s      = 1'b0;
    assign stall_timeout        = 1'b0;
`endif

    assign active_s = (state_r == RUN) || (state_r == STEP);
    assign retire_s = wb_valid && out_s.wb_en;

    pipe_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk           (clk),
        .rst           (rst),
        .clear         (counter_clear_s),
        .active        (active_s),
        .retire        (retire_s),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );

endmodule

// File: tb/tb_pipeline_run_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_run_controller
// Directed stimulus with hand-computed literal expectations, plus a
// behavioural reference model compared against the DUT on every falling edge.
// Counters are narrowed to 8 bits so wrap-around is reached quickly; the
// watchdog limit is 4 so the optional feature is exercised when enabled.
// -----------------------------------------------------------------------------
module tb_pipeline_run_controller;

    localparam int CNT_W_TB = 8;
    localparam int LIMIT_TB = 4;
    localparam int CNT_MOD  = 1 << CNT_W_TB;

`ifdef PIPE_CTRL_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;
    localparam int S_STEP = 3;

    logic clk = 1'b0;
    logic rst, start, halt_req, step_req, resume_req;
    logic hazard_detected, insert_bubble, branch_taken, wb_valid;
    logic fetch_en, decode_en, execute_en, mem_en, wb_en;
    logic decode_flush, execute_flush, mem_flush;
    logic running, halted, stall_timeout;
    logic [CNT_W_TB-1:0] cycle_count, instret_count;
    logic [7:0] dut_ctrl;

    int n_checks = 0;
    int n_errors = 0;
    bit done = 1'b0;

    // reference model state
    int m_state = S_IDLE;
    int m_cyc   = 0;
    int m_ret   = 0;
    int m_stall = 0;
    bit m_to    = 1'b0;

    pipeline_run_controller #(
        .CNT_W       (CNT_W_TB),
        .STALL_LIMIT (LIMIT_TB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .halt_req        (halt_req),
        .step_req        (step_req),
        .resume_req      (resume_req),
        .hazard_detected (hazard_detected),
        .insert_bubble   (insert_bubble),
        .branch_taken    (branch_taken),
        .wb_valid        (wb_valid),
        .fetch_en        (fetch_en),
        .decode_en       (decode_en),
        .execute_en      (execute_en),
        .mem_en          (mem_en),
        .wb_en           (wb_en),
        .decode_flush    (decode_flush),
        .execute_flush   (execute_flush),
        .mem_flush       (mem_flush),
        .running         (running),
        .halted          (halted),
        .stall_timeout   (stall_timeout),
        .cycle_count     (cycle_count),
        .instret_count   (instret_count)
    );

    assign dut_ctrl = {fetch_en, decode_en, execute_en, mem_en, wb_en,
                       decode_flush, execute_flush, mem_flush};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected {fetch,decode,execute,mem,wb | dflush,eflush,mflush} this cycle.
    function automatic logic [7:0] exp_ctrl();
        logic [4:0] en;
        logic [2:0] fl;
        en = 5'b00000;
        fl = 3'b000;
        if (!rst) begin
            en = 5'b00000; fl = 3'b000;
        end else if (!start || m_state == S_IDLE) begin
            en = 5'b00000; fl = 3'b111;
        end else if (m_state == S_HALT) begin
            en = 5'b00000; fl = 3'b000;
        end else if (halt_req && wb_valid) begin
            en = 5'b01111; fl = 3'b111;
        end else if (branch_taken) begin
            en = 5'b11111; fl = 3'b111;
        end else if (insert_bubble) begin
            en = 5'b00011; fl = 3'b001;
        end else if (hazard_detected) begin
            en = 5'b00111; fl = 3'b010;
        end else begin
            en = 5'b11111; fl = 3'b000;
        end
        return {en, fl};
    endfunction

    function automatic bit exp_fetch();
        return (exp_ctrl() & 8'h80) != 8'h00;
    endfunction

    function automatic bit exp_wb();
        return (exp_ctrl() & 8'h08) != 8'h00;
    endfunction

    // Reference model: advance state and counters on each clock.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state <= S_IDLE;
            m_cyc   <= 0;
            m_ret   <= 0;
            m_stall <= 0;
            m_to    <= 1'b0;
        end else begin
            if (m_state == S_RUN || m_state == S_STEP) m_cyc <= (m_cyc + 1) % CNT_MOD;
            if (wb_valid && exp_wb()) m_ret <= (m_ret + 1) % CNT_MOD;
            if (start && m_state == S_RUN && !exp_fetch()) m_stall <= m_stall + 1;
            else m_stall <= 0;
            if (!start) begin
                m_state <= S_IDLE;
            end else if (m_state == S_IDLE) begin
                m_state <= S_RUN;
                m_cyc   <= 0;
                m_ret   <= 0;
                m_to    <= 1'b0;
            end else if (m_state == S_HALT) begin
                if (resume_req) m_state <= S_RUN;
                else if (step_req) m_state <= S_STEP;
            end else if (halt_req && wb_valid) begin
                m_state <= S_HALT;
            end else if (m_state == S_STEP) begin
                m_state <= S_HALT;
            end else if (WD && !exp_fetch() && m_stall + 1 == LIMIT_TB) begin
                m_state <= S_HALT;
                m_to    <= 1'b1;
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (!done) begin
            chk("stage_ctrl",    32'(dut_ctrl),      32'(exp_ctrl()));
            chk("running",       32'(running),       32'(m_state == S_RUN));
            chk("halted",        32'(halted),        32'(m_state == S_HALT));
            chk("stall_timeout", 32'(stall_timeout), 32'(m_to));
            chk("cycle_count",   32'(cycle_count),   32'(m_cyc));
            chk("instret_count", 32'(instret_count), 32'(m_ret));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; start = 1'b1; halt_req = 1'b0; step_req = 1'b0;
        resume_req = 1'b0; hazard_detected = 1'b0; insert_bubble = 1'b0;
        branch_taken = 1'b0; wb_valid = 1'b0;

        // 1. reset, then IDLE -> RUN with one flush cycle and counting
        tick(); tick(); #3;
        chk("rst_ctrl", 32'(dut_ctrl), 32'h00);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_cycles", 32'(cycle_count), 32'd0);
        tick(); rst = 1'b1; #3;
        chk("idle_flush", 32'(dut_ctrl), 32'h07);
        tick(); #3;
        chk("run_entry", 32'(running), 32'd1);
        chk("run_flow", 32'(dut_ctrl), 32'hF8);
        chk("run_cyc0", 32'(cycle_count), 32'd0);
        repeat (10) tick();
        #3; chk("cyc_10", 32'(cycle_count), 32'd10);

        // 2. one-cycle load-use hazard
        tick(); hazard_detected = 1'b1; #3;
        chk("hazard_ctrl", 32'(dut_ctrl), 32'h3A);
        tick(); hazard_detected = 1'b0; #3;
        chk("hazard_release", 32'(dut_ctrl), 32'hF8);

        // 3. bubble for 3 cycles with a taken branch in the middle
        tick(); insert_bubble = 1'b1; #3;
        chk("bubble_1", 32'(dut_ctrl), 32'h19);
        tick(); branch_taken = 1'b1; #3;
        chk("bubble_branch", 32'(dut_ctrl), 32'hFF);
        tick(); branch_taken = 1'b0; #3;
        chk("bubble_3", 32'(dut_ctrl), 32'h19);

        // 4. ebreak retires: squash younger, WB completes, then frozen
        tick(); insert_bubble = 1'b0; halt_req = 1'b1; wb_valid = 1'b1; #3;
        chk("halt_squash", 32'(dut_ctrl), 32'h7F);
        chk("halt_cyc", 32'(cycle_count), 32'd16);
        tick(); halt_req = 1'b0; wb_valid = 1'b0; #3;
        chk("halted", 32'(halted), 32'd1);
        chk("halt_ctrl", 32'(dut_ctrl), 32'h00);
        chk("halt_instret", 32'(instret_count), 32'd1);
        tick(); #3;
        chk("halt_frozen", 32'(cycle_count), 32'd17);

        // 5. single step, step with squash, resume+step together
        tick(); step_req = 1'b1; #3;
        chk("step_req_halted", 32'(halted), 32'd1);
        tick(); step_req = 1'b0; #3;
        chk("step_ctrl", 32'(dut_ctrl), 32'hF8);
        chk("step_not_halted", 32'(halted), 32'd0);
        tick(); #3;
        chk("step_back", 32'(halted), 32'd1);
        chk("step_cyc", 32'(cycle_count), 32'd18);
        tick(); step_req = 1'b1; #3;
        tick(); step_req = 1'b0; halt_req = 1'b1; wb_valid = 1'b1; #3;
        chk("step_squash", 32'(dut_ctrl), 32'h7F);
        tick(); halt_req = 1'b0; wb_valid = 1'b0; #3;
        chk("step_instret", 32'(instret_count), 32'd2);
        tick(); resume_req = 1'b1; step_req = 1'b1; #3;
        tick(); resume_req = 1'b0; step_req = 1'b0; #3;
        chk("resume_wins", 32'(running), 32'd1);
        chk("resume_cyc", 32'(cycle_count), 32'd19);

        // halt_req without wb_valid is ignored
        tick(); halt_req = 1'b1; #3;
        chk("halt_unqual", 32'(dut_ctrl), 32'hF8);
        tick(); halt_req = 1'b0; #3;
        chk("halt_unqual_run", 32'(running), 32'd1);

        // counter wrap: retire every cycle until instret wraps to 0
        tick(); wb_valid = 1'b1; #3;
        chk("pre_wrap_cyc", 32'(cycle_count), 32'd22);
        repeat (254) tick();
        #3;
        chk("instret_wrap", 32'(instret_count), 32'd0);
        chk("cycle_wrap", 32'(cycle_count), 32'd20);

        // 6. hazard held: watchdog trips on the 4th stall cycle when built in
        tick(); wb_valid = 1'b0; hazard_detected = 1'b1; #3;
        repeat (4) tick();
        #3;
        chk("wd_halted", 32'(halted), 32'(WD));
        chk("wd_flag", 32'(stall_timeout), 32'(WD));
        tick(); hazard_detected = 1'b0; start = 1'b0; #3;
        chk("unload_flush", 32'(dut_ctrl), 32'h07);
        tick(); start = 1'b1; #3;
        chk("reload_idle", 32'(running), 32'd0);
        chk("wd_sticky", 32'(stall_timeout), 32'(WD));
        tick(); #3;
        chk("restart_cyc", 32'(cycle_count), 32'd0);
        chk("restart_instret", 32'(instret_count), 32'd0);
        chk("wd_cleared", 32'(stall_timeout), 32'd0);

        // asynchronous reset mid-run
        repeat (3) tick();
        rst = 1'b0; #3;
        chk("async_rst_running", 32'(running), 32'd0);
        chk("async_rst_cyc", 32'(cycle_count), 32'd0);
        chk("async_rst_ctrl", 32'(dut_ctrl), 32'h00);
        tick(); rst = 1'b1;
        repeat (3) tick();
        #3;
        chk("post_rst_cyc", 32'(cycle_count), 32'd2);

        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
